// File: rtl/four_bank_mem_responder.sv
// Four word-interleaved 16-bit banks with per-bank occupancy counters
// and a fixed two-cycle read return path.
module four_bank_mem_responder #(
  parameter int BANK_CYCLES = 4,
  parameter int BANK_ADDR_W = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int CW = (BANK_CYCLES > 1) ? $clog2(BANK_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BANK_CYCLES - 1);
  localparam int AW = BANK_ADDR_W + 2;

  logic [15:0]   r_mem [2**AW];
  logic [CW-1:0] r_cnt [4];
  logic          r_s1_v;
  logic [AW-1:0] r_s1_addr;
  logic          r_dv;
  logic [15:0]   r_dout;
  logic          r_err;

  logic [1:0]    w_bank;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_busy;
  logic          w_acc;
  logic          w_bad;

  assign w_bank = addr[2:1];
  assign w_addr = {w_bank, addr[3 +: BANK_ADDR_W]};

  always_comb begin
    w_busy = '0;
    for (int b = 0; b < 4; b++) begin
      w_busy[b] = (r_cnt[b] != '0);
    end
  end

  assign w_acc = (rd ^ wr) & ~addr[0] & ~w_busy[w_bank] & ~rst;
  assign w_bad = (rd & wr) | ((rd | wr) & addr[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc && (w_bank == 2'(b))) begin
          r_cnt[b] <= LOAD;
        end else if (r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - CW'(1);
        end
      end
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_acc && wr) begin
      r_mem[w_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_addr <= '0;
      r_dv      <= 1'b0;
      r_dout    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_s1_v    <= w_acc & rd;
      r_s1_addr <= w_addr;
      r_dv      <= r_s1_v;
      r_dout    <= r_s1_v ? r_mem[r_s1_addr] : 16'h0000;
      r_err     <= w_bad;
    end
  end

  assign data_out   = r_dout;
  assign data_valid = r_dv;
  assign busy       = w_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_four_bank_mem_responder.sv
// Directed bench for four_bank_mem_responder with a cycle-level
// reference model and a per-cycle output comparator.
module tb_four_bank_mem_responder;

  localparam int BC = 4;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem_responder #(.BANK_CYCLES(BC), .BANK_ADDR_W(13)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .wr(wr), .rd(rd), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic [15:0] d;
  } pend_t;

  // Model state: when each bank frees up, memory image, pending returns.
  int          cyc = 0;
  int          free_at [4];
  logic [15:0] mmem [int];
  pend_t       pq [$];
  bit          chk_en = 0;
  logic [15:0] e_dout;
  logic        e_dv;
  logic [3:0]  e_busy;
  logic        e_err;

  always @(posedge clk) begin
    int b;
    int key;
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      pq.delete();
      e_err = 1'b0;
      chk_en = 1;
    end else begin
      e_err = (rd & wr) | ((rd | wr) & addr[0]);
      b = int'(addr[2:1]);
      key = b * 8192 + int'(addr[15:3]);
      acc = (rd ^ wr) && !addr[0] && (cyc >= free_at[b]);
      if (acc) begin
        free_at[b] = cyc + BC;
        if (wr) mmem[key] = data_in;
        if (rd) pq.push_back('{due: cyc + 2, d: mmem.exists(key) ? mmem[key] : 16'hxxxx});
      end
    end
    e_dv = 1'b0;
    e_dout = 16'h0000;
    if (pq.size() > 0 && pq[0].due == cyc + 1) begin
      e_dv = 1'b1;
      e_dout = pq[0].d;
      void'(pq.pop_front());
    end
    for (int i = 0; i < 4; i++) e_busy[i] = (cyc + 1 < free_at[i]);
    cyc++;
  end

  // Observed returns and error pulses for the literal checks.
  logic [15:0] got [$];
  int          got_cyc [$];
  int          n_err = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(e_busy));
      chk("err", 16'(err), 16'(e_err));
      chk("data_valid", 16'(data_valid), 16'(e_dv));
      chk("data_out", data_out, e_dout);
      if (data_valid === 1'b1) begin
        got.push_back(data_out);
        got_cyc.push_back(cyc);
      end
      if (err === 1'b1) n_err++;
    end
  end

  task automatic drv(logic r, logic w, logic [15:0] a, logic [15:0] d);
    rd = r;
    wr = w;
    addr = a;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) drv(0, 0, 16'h0, 16'h0);
  endtask

  logic [15:0] exp_lst [8];

  initial begin
    rst = 1'b1;
    rd = 0;
    wr = 0;
    addr = 0;
    data_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_dout", data_out, 16'h0);
    rst = 1'b0;

    // write then read back, bank 1
    drv(0, 1, 16'h0A12, 16'hBEEF);
    idle(3);
    drv(1, 0, 16'h0A12, 16'h0);
    idle(4);

    // line fill: writes to four banks, then back-to-back reads
    drv(0, 1, 16'h0100, 16'h1111);
    drv(0, 1, 16'h0102, 16'h2222);
    drv(0, 1, 16'h0104, 16'h3333);
    drv(0, 1, 16'h0106, 16'h4444);
    idle(4);
    drv(1, 0, 16'h0100, 16'h0);
    drv(1, 0, 16'h0102, 16'h0);
    drv(1, 0, 16'h0104, 16'h0);
    drv(1, 0, 16'h0106, 16'h0);
    idle(4);

    // busy rejection on bank 0
    drv(0, 1, 16'h0200, 16'h5A5A);
    idle(3);
    drv(1, 0, 16'h0200, 16'h0);
    drv(0, 1, 16'h0200, 16'hDEAD);
    idle(2);
    drv(1, 0, 16'h0200, 16'h0);
    idle(4);

    // protocol errors
    drv(1, 1, 16'h0010, 16'h1234);
    drv(1, 0, 16'h0003, 16'h0);
    idle(4);

    // reset mid-read
    drv(0, 1, 16'h0300, 16'h7777);
    idle(3);
    drv(1, 0, 16'h0300, 16'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    drv(1, 0, 16'h0300, 16'h0);
    idle(4);

    exp_lst = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333,
                16'h4444, 16'h5A5A, 16'h5A5A, 16'h7777};
    chk("n_returns", 16'(got.size()), 16'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ret%0d", i), (i < got.size()) ? got[i] : 16'hxxxx, exp_lst[i]);
    end
    chk("n_err", 16'(n_err), 16'd2);
    if (got_cyc.size() >= 5) begin
      chk("fill_back2back", 16'(got_cyc[4] - got_cyc[1]), 16'd3);
    end else begin
      chk("fill_back2back", 16'hxxxx, 16'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
